// File: rtl/ocp_burst_slave_mem.sv
// OCP slave target: tagged burst commands are queued and then executed in order against a word memory.
// Define OCP_WRAP_BURST_EN to support WRAP bursts (m_burst_seq 3'b010) with power-of-two lengths.
module ocp_burst_slave_mem #(
  parameter int TAGI_WIDTH = 5,
  parameter int INFO_WIDTH = 4,
  parameter int BLEN_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CMDQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [BLEN_WIDTH-1:0]   m_burst_lenght,
  input  logic [2:0]              m_burst_seq,
  input  logic [DATA_WIDTH/8-1:0] m_byteen,
  input  logic [2:0]              m_cmd,
  input  logic [DATA_WIDTH-1:0]   m_data,
  input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
  input  logic                    m_data_last,
  input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
  input  logic                    m_data_valid,
  input  logic [INFO_WIDTH-1:0]   m_req_info,
  input  logic                    m_resp_accept,
  input  logic [TAGI_WIDTH-1:0]   m_tagid,
  output logic                    s_cmd_accept,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_data_accept,
  output logic [1:0]              s_resp,
  output logic                    s_resp_last,
  output logic [TAGI_WIDTH-1:0]   s_tagid
);

  localparam int PTR_W  = $clog2(CMDQ_DEPTH);
  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] SEQ_INCR = 3'b000;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RRESP, ST_WRESP} state_t;

  // blen holds the effective beat count; ok/wrap are the burst-sequence decode done at push time.
  typedef struct packed {
    logic [2:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BLEN_WIDTH-1:0] blen;
    logic                  ok;
    logic                  wrap;
    logic [TAGI_WIDTH-1:0] tag;
  } cmd_entry_t;

  cmd_entry_t            cmdq_mem [CMDQ_DEPTH];
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  queue_full, queue_empty, push, pop;
  logic [BLEN_WIDTH-1:0] push_blen;
  logic                  push_ok, push_wrap;
  cmd_entry_t            push_entry, head;

  state_t                state_q, state_d;
  cmd_entry_t            cur_q, cur_d;
  logic [BLEN_WIDTH-1:0] beat_q, beat_d;
  logic                  err_q, err_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_q, last_d;
  logic [TAGI_WIDTH-1:0] tag_q, tag_d;

  logic                  mem_we, wbeat_tag_ok, wbeat_last;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  unused_inputs;

  assign unused_inputs = ^{m_byteen, m_req_info};

  // Wrap bursts keep the upper address bits fixed; INCR uses an all-ones mask and wraps at the memory top.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input cmd_entry_t e,
                                                      input logic [BLEN_WIDTH-1:0] beat);
    logic [ADDR_WIDTH-1:0] incr, mask;
    incr = e.addr + ADDR_WIDTH'(beat);
    mask = e.wrap ? ADDR_WIDTH'(e.blen - 1'b1) : '1;
    return (e.addr & ~mask) | (incr & mask);
  endfunction

  assign push_blen = (m_burst_lenght == '0) ? BLEN_WIDTH'(1) : m_burst_lenght;
`ifdef OCP_WRAP_BURST_EN
  assign push_wrap = (m_burst_seq == 3'b010);
  assign push_ok   = (m_burst_seq == SEQ_INCR) ||
                     (push_wrap && ((push_blen & (push_blen - 1'b1)) == '0));
`else
  assign push_wrap = 1'b0;
  assign push_ok   = (m_burst_seq == SEQ_INCR);
`endif

  assign queue_full   = (count_q == (PTR_W+1)'(CMDQ_DEPTH));
  assign queue_empty  = (count_q == '0);
  assign s_cmd_accept = rst_n && !queue_full;
  assign push         = (m_cmd != 3'b000) && s_cmd_accept;
  assign pop          = (state_q == ST_IDLE) && !queue_empty;
  assign head         = cmdq_mem[rd_ptr_q];
  assign push_entry   = '{cmd: m_cmd, addr: m_addr, blen: push_blen, ok: push_ok,
                          wrap: push_wrap, tag: m_tagid};

  // NOTE: storage arrays carry no reset; only the pointers and count qualify their contents.
  always_ff @(posedge clk) begin
    if (push) cmdq_mem[wr_ptr_q] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign wbeat_tag_ok  = (m_data_tagid == cur_q.tag);
  assign wbeat_last    = (beat_q == cur_q.blen - 1'b1);
  assign mem_waddr     = beat_addr(cur_q, beat_q);
  assign s_data_accept = (state_q == ST_WDATA);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    err_d   = err_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    tag_d   = tag_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!queue_empty) begin
          cur_d  = head;
          beat_d = '0;
          err_d  = 1'b0;
          tag_d  = head.tag;
          if (head.cmd == CMD_WR) begin
            state_d = ST_WDATA;
          end else if (head.cmd == CMD_RD) begin
            state_d = ST_RRESP;
            resp_d  = head.ok ? RESP_DVA : RESP_ERR;
            rdata_d = head.ok ? mem[beat_addr(head, '0)] : '0;
            last_d  = (head.blen == BLEN_WIDTH'(1));
          end else begin
            state_d = ST_WRESP;
            resp_d  = RESP_ERR;
            last_d  = 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (m_data_valid) begin
          mem_we = wbeat_tag_ok && cur_q.ok;
          err_d  = err_q || !wbeat_tag_ok || !cur_q.ok || (m_data_last != wbeat_last);
          if (wbeat_last) begin
            state_d = ST_WRESP;
            resp_d  = err_d ? RESP_ERR : RESP_DVA;
            last_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RRESP: begin
        if (m_resp_accept) begin
          if (last_q) begin
            state_d = ST_IDLE;
            resp_d  = RESP_NULL;
            last_d  = 1'b0;
          end else begin
            beat_d  = beat_q + 1'b1;
            rdata_d = cur_q.ok ? mem[beat_addr(cur_q, beat_d)] : '0;
            last_d  = (beat_d == cur_q.blen - 1'b1);
          end
        end
      end
      ST_WRESP: begin
        if (m_resp_accept) begin
          state_d = ST_IDLE;
          resp_d  = RESP_NULL;
          last_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= RESP_NULL;
      rdata_q <= '0;
      last_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (m_data_byteen[b]) mem[mem_waddr][b*8 +: 8] <= m_data[b*8 +: 8];
      end
    end
  end

  assign s_resp      = resp_q;
  assign s_data      = rdata_q;
  assign s_resp_last = last_q;
  assign s_tagid     = tag_q;

endmodule

// File: tb/tb_ocp_burst_slave_mem.sv
// Self-checking bench for ocp_burst_slave_mem: random bursts against an array-based memory model.
`timescale 1ns/1ps
module tb_ocp_burst_slave_mem;

  localparam int TW = 5, IW = 4, BW = 4, DW = 32, AW = 5, QD = 4, NB = DW / 8, MEMW = 2**AW;
`ifdef OCP_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam logic [1:0] R_NULL = 2'b00, R_DVA = 2'b01, R_ERR = 2'b11;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_burst_lenght = '0;
  logic [2:0]    m_burst_seq = '0, m_cmd = '0;
  logic [NB-1:0] m_byteen = '1, m_data_byteen = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_data_last = 1'b0, m_data_valid = 1'b0, m_resp_accept = 1'b1;
  logic [TW-1:0] m_data_tagid = '0, m_tagid = '0;
  logic [IW-1:0] m_req_info = '0;
  logic          s_cmd_accept, s_data_accept, s_resp_last;
  logic [DW-1:0] s_data;
  logic [1:0]    s_resp;
  logic [TW-1:0] s_tagid;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] ref_mem [MEMW];
  logic [DW-1:0] wdata [16];
  logic [NB-1:0] wbe [16];

  ocp_burst_slave_mem #(.TAGI_WIDTH(TW), .INFO_WIDTH(IW), .BLEN_WIDTH(BW), .DATA_WIDTH(DW),
                        .ADDR_WIDTH(AW), .CMDQ_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_burst_lenght(m_burst_lenght),
    .m_burst_seq(m_burst_seq), .m_byteen(m_byteen), .m_cmd(m_cmd), .m_data(m_data),
    .m_data_byteen(m_data_byteen), .m_data_last(m_data_last), .m_data_tagid(m_data_tagid),
    .m_data_valid(m_data_valid), .m_req_info(m_req_info), .m_resp_accept(m_resp_accept),
    .m_tagid(m_tagid), .s_cmd_accept(s_cmd_accept), .s_data(s_data),
    .s_data_accept(s_data_accept), .s_resp(s_resp), .s_resp_last(s_resp_last), .s_tagid(s_tagid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff_len(int blen);
    return (blen == 0) ? 1 : blen;
  endfunction

  function automatic bit seq_supported(int seq, int blen);
    int n = eff_len(blen);
    if (seq == 0) return 1'b1;
    if (seq == 2 && WRAP_EN) return (n == 1 || n == 2 || n == 4 || n == 8);
    return 1'b0;
  endfunction

  function automatic int model_addr(int addr, int blen, int seq, int beat);
    int n = eff_len(blen);
    int base;
    if (seq == 2) begin
      base = addr - (addr % n);
      return base + ((addr + beat) % n);
    end
    return (addr + beat) % MEMW;
  endfunction

  task automatic issue(input logic [2:0] cmd, input int addr, input int blen,
                       input logic [2:0] seq, input int tag);
    int w = 0;
    @(negedge clk);
    m_cmd = cmd; m_addr = AW'(addr); m_burst_lenght = BW'(blen);
    m_burst_seq = seq; m_tagid = TW'(tag);
    while (s_cmd_accept !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (s_cmd_accept !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout: accept=%b required 1", s_cmd_accept);
    end
    @(negedge clk);
    m_cmd = 3'b000;
  endtask

  // Samples the beat visible at the current negedge, then steps one cycle so it gets accepted.
  task automatic get_beat(output logic [1:0] r, output logic [DW-1:0] d,
                          output logic l, output logic [TW-1:0] t);
    int w = 0;
    while (s_resp === R_NULL && w < 200) begin @(negedge clk); w++; end
    if (s_resp === R_NULL) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: s_resp=%b required non-NULL", s_resp);
    end
    r = s_resp; d = s_data; l = s_resp_last; t = s_tagid;
    @(negedge clk);
  endtask

  task automatic write_burst(input int addr, input int blen, input int seq, input int tag,
                             input int bad_tag_beat, input int bad_last_beat);
    int n = eff_len(blen);
    bit ok = seq_supported(seq, blen);
    bit exp_err = !ok;
    int a, w;
    logic [1:0] r; logic [DW-1:0] d; logic l; logic [TW-1:0] t;
    issue(3'b001, addr, blen, 3'(seq), tag);
    for (int b = 0; b < n; b++) begin
      m_data_valid = 1'b1; m_data = wdata[b]; m_data_byteen = wbe[b];
      m_data_tagid = TW'((b == bad_tag_beat) ? tag + 1 : tag);
      m_data_last = (b == n - 1) ^ (b == bad_last_beat);
      w = 0;
      while (s_data_accept !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      if (s_data_accept !== 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL data_accept_timeout: beat %0d accept=%b required 1", b, s_data_accept);
      end
      @(negedge clk);
      if (b == bad_tag_beat || b == bad_last_beat) exp_err = 1'b1;
      if (ok && b != bad_tag_beat) begin
        a = model_addr(addr, blen, seq, b);
        for (int k = 0; k < NB; k++)
          if (wbe[b][k]) ref_mem[a][k*8 +: 8] = wdata[b][k*8 +: 8];
      end
    end
    m_data_valid = 1'b0; m_data_last = 1'b0;
    get_beat(r, d, l, t);
    n_cmp++;
    if ({r, l, t} !== {(exp_err ? R_ERR : R_DVA), 1'b1, TW'(tag)}) begin
      n_err++;
      $display("FAIL wr_resp addr=%0d len=%0d: resp=%b last=%b tag=%0d required resp=%b last=1 tag=%0d",
               addr, blen, r, l, t, exp_err ? R_ERR : R_DVA, tag);
    end
  endtask

  task automatic check_read_beat(input int addr, input int blen, input int seq, input int tag,
                                 input int b, input logic [1:0] r, input logic [DW-1:0] d,
                                 input logic l, input logic [TW-1:0] t);
    bit ok = seq_supported(seq, blen);
    logic [1:0]    er = ok ? R_DVA : R_ERR;
    logic [DW-1:0] ed = ok ? ref_mem[model_addr(addr, blen, seq, b)] : '0;
    logic          el = (b == eff_len(blen) - 1);
    n_cmp++;
    if ({r, d, l, t} !== {er, ed, el, TW'(tag)}) begin
      n_err++;
      $display("FAIL rd_beat addr=%0d len=%0d seq=%0d beat=%0d: resp=%b data=%h last=%b tag=%0d required resp=%b data=%h last=%b tag=%0d",
               addr, blen, seq, b, r, d, l, t, er, ed, el, tag);
    end
  endtask

  task automatic read_burst(input int addr, input int blen, input int seq, input int tag);
    logic [1:0] r; logic [DW-1:0] d; logic l; logic [TW-1:0] t;
    issue(3'b010, addr, blen, 3'(seq), tag);
    for (int b = 0; b < eff_len(blen); b++) begin
      get_beat(r, d, l, t);
      check_read_beat(addr, blen, seq, tag, b, r, d, l, t);
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({s_cmd_accept, s_data_accept, s_resp, s_resp_last} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_hold: accept=%b daccept=%b resp=%b last=%b required all 0",
               s_cmd_accept, s_data_accept, s_resp, s_resp_last);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({s_cmd_accept, s_data_accept, s_resp, s_resp_last, s_data, s_tagid} !==
        {1'b1, 1'b0, R_NULL, 1'b0, {DW{1'b0}}, {TW{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state: accept=%b daccept=%b resp=%b last=%b data=%h tag=%0d required 1 0 00 0 0 0",
               s_cmd_accept, s_data_accept, s_resp, s_resp_last, s_data, s_tagid);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 8; b++) begin wdata[b] = $urandom; wbe[b] = '1; end
      write_burst(i * 8, 8, 0, $urandom_range(0, 31), -1, -1);
    end
  endtask

  task automatic test_wr_rd_basic;
    for (int b = 0; b < 4; b++) begin wdata[b] = DW'(32'hA0 + b); wbe[b] = 4'hF; end
    write_burst(4, 4, 0, 3, -1, -1);
    read_burst(4, 4, 0, 3);
    read_burst(9, 0, 0, 4);
  endtask

  task automatic test_addr_wrap;
    read_burst(30, 4, 0, 21);
  endtask

  task automatic test_tag_mismatch;
    for (int b = 0; b < 2; b++) begin wdata[b] = $urandom; wbe[b] = '1; end
    write_burst(10, 2, 0, 5, 1, -1);
    read_burst(10, 2, 0, 6);
    for (int b = 0; b < 3; b++) begin wdata[b] = $urandom; wbe[b] = '1; end
    write_burst(12, 3, 0, 9, -1, 1);
    read_burst(12, 3, 0, 9);
  endtask

  task automatic test_illegal_cmd;
    logic [1:0] r; logic [DW-1:0] d; logic l; logic [TW-1:0] t;
    issue(3'b111, 0, 4, 3'b000, 7);
    get_beat(r, d, l, t);
    n_cmp++;
    if ({r, l, t} !== {R_ERR, 1'b1, TW'(7)}) begin
      n_err++;
      $display("FAIL illegal_cmd: resp=%b last=%b tag=%0d required resp=11 last=1 tag=7", r, l, t);
    end
    read_burst(1, 2, 0, 8);
  endtask

  task automatic test_wrap_burst;
    read_burst(6, 4, 2, 11);
    for (int b = 0; b < 4; b++) begin wdata[b] = $urandom; wbe[b] = '1; end
    write_burst(13, 4, 2, 12, -1, -1);
    read_burst(12, 4, 0, 13);
    for (int b = 0; b < 3; b++) begin wdata[b] = $urandom; wbe[b] = '1; end
    write_burst(20, 3, 2, 14, -1, -1);
    read_burst(20, 3, 2, 15);
  endtask

  task automatic test_random;
    int addr, blen, seq, tag, bad;
    int seqs [5] = '{0, 0, 0, 2, 1};
    for (int i = 0; i < 30; i++) begin
      addr = $urandom_range(0, MEMW - 1);
      blen = $urandom_range(0, 15);
      seq  = seqs[$urandom_range(0, 4)];
      tag  = $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin wdata[b] = $urandom; wbe[b] = NB'($urandom); end
        bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, eff_len(blen) - 1) : -1;
        write_burst(addr, blen, seq, tag, bad, -1);
      end else begin
        read_burst(addr, blen, seq, tag);
      end
    end
  endtask

  task automatic test_back_to_back;
    int addrs [5];
    logic [1:0] r; logic [DW-1:0] d; logic l; logic [TW-1:0] t;
    m_resp_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addrs[i] = $urandom_range(0, MEMW - 1);
      m_cmd = 3'b010; m_addr = AW'(addrs[i]); m_burst_lenght = BW'(2);
      m_burst_seq = 3'b000; m_tagid = TW'(16 + i);
      n_cmp++;
      if (s_cmd_accept !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_accept cmd %0d: accept=%b required 1", i, s_cmd_accept);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (s_cmd_accept !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full: accept=%b required 0", s_cmd_accept);
    end
    m_cmd = 3'b000;
    for (int k = 0; k < 3; k++) begin
      check_read_beat(addrs[0], 2, 0, 16, 0, s_resp, s_data, s_resp_last, s_tagid);
      @(negedge clk);
    end
    m_resp_accept = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int b = 0; b < 2; b++) begin
        get_beat(r, d, l, t);
        check_read_beat(addrs[i], 2, 0, 16 + i, b, r, d, l, t);
      end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wr_rd_basic();
    test_addr_wrap();
    test_tag_mismatch();
    test_illegal_cmd();
    test_wrap_burst();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
